// File: rtl/bcd_segment_pkg.sv
// Shared constants and helpers for the BCD seven-segment counter.
// Segment vectors are active-low, ordered {G,F,E,D,C,B,A}.
package bcd_segment_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam bcd_digit_t BCD_MAX   = 4'd9;
  localparam bcd_digit_t BCD_MIN   = 4'd0;

  function automatic logic [6:0] bcd_to_seg(input bcd_digit_t d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Out-of-range nibbles collapse to zero so the register never holds a non-BCD code.
  function automatic bcd_digit_t bcd_sanitize(input logic [3:0] n);
    return (n > BCD_MAX) ? BCD_MIN : n;
  endfunction

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
  endfunction

  function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
    return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_to_segment.sv
// Combinational decode of one BCD digit to active-low segments, with blanking.
module bcd_to_segment
  import bcd_segment_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] segments
);

  assign segments = blank ? SEG_BLANK : bcd_to_seg(digit);

endmodule

// File: rtl/bcd_segment_counter.sv
// N-digit BCD up/down counter with prescaler, parallel load, wrap pulse and
// per-digit active-low 7-segment outputs (combinational from the digit registers).
module bcd_segment_counter
  import bcd_segment_pkg::*;
#(
  parameter int NUM_DIGITS          = 2,
  parameter int TICK_COUNT          = 12_500_000,
  parameter bit BLANK_LEADING_ZEROS = 1'b0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic                    i_Run,
  input  logic                    i_Up,
  input  logic                    i_Load,
  input  logic [4*NUM_DIGITS-1:0] i_Load_Bcd,
  output logic [4*NUM_DIGITS-1:0] o_Count_Bcd,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam int PW = $clog2(TICK_COUNT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);

  logic [PW-1:0]                  presc_reg;
  logic                           tick;
  logic                           wrap_reg;
  logic [NUM_DIGITS-1:0][3:0]     digit_reg;
  logic [NUM_DIGITS-1:0][3:0]     digit_next;
  logic [NUM_DIGITS:0]            carry;
  logic [NUM_DIGITS:0]            borrow;
  logic [NUM_DIGITS-1:0]          lead_zero;

  assign tick = i_Run && (presc_reg == PRESC_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc_reg <= '0;
    end else if (i_Load || tick) begin
      presc_reg <= '0;
    end else if (i_Run) begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  // Wrap fires when the ripple reaches past the top digit, i.e. every digit rolled over.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wrap_reg <= 1'b0;
    end else if (i_Load) begin
      wrap_reg <= 1'b0;
    end else if (tick) begin
      wrap_reg <= i_Up ? carry[NUM_DIGITS] : borrow[NUM_DIGITS];
    end else begin
      wrap_reg <= 1'b0;
    end
  end

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;
  assign o_Wrap    = wrap_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign carry[gi+1]  = carry[gi]  && (digit_reg[gi] == BCD_MAX);
      assign borrow[gi+1] = borrow[gi] && (digit_reg[gi] == BCD_MIN);

      always_comb begin
        digit_next[gi] = digit_reg[gi];
        if (i_Up && carry[gi]) begin
          digit_next[gi] = bcd_inc(digit_reg[gi]);
        end else if (!i_Up && borrow[gi]) begin
          digit_next[gi] = bcd_dec(digit_reg[gi]);
        end
      end

      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          digit_reg[gi] <= BCD_MIN;
        end else if (i_Load) begin
          digit_reg[gi] <= bcd_sanitize(i_Load_Bcd[4*gi +: 4]);
        end else if (tick) begin
          digit_reg[gi] <= digit_next[gi];
        end
      end

      // lead_zero[k]: digit k and every digit above it are zero.
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lead_zero[gi] = (digit_reg[gi] == BCD_MIN);
      end else begin : g_lower
        assign lead_zero[gi] = (digit_reg[gi] == BCD_MIN) && lead_zero[gi+1];
      end

      bcd_to_segment u_seg (
        .digit    (digit_reg[gi]),
        .blank    (BLANK_LEADING_ZEROS && (gi != 0) && lead_zero[gi]),
        .segments (o_Segments[7*gi +: 7])
      );

      assign o_Count_Bcd[4*gi +: 4] = digit_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_bcd_segment_counter.sv
// Scoreboard bench: a decimal-integer model predicts each edge's result, a
// negedge monitor compares it against a 2-digit and a 3-digit blanking instance.
module tb_bcd_segment_counter;

  localparam int TC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, up, load;
  logic [11:0] load_bcd;

  logic [7:0]  cnt2;
  logic [13:0] seg2;
  logic        wrap2;
  logic [11:0] cnt3;
  logic [20:0] seg3;
  logic        wrap3;

  always #5 clk = ~clk;

  bcd_segment_counter #(.NUM_DIGITS(2), .TICK_COUNT(TC), .BLANK_LEADING_ZEROS(1'b0)) dut2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Run(run), .i_Up(up), .i_Load(load),
    .i_Load_Bcd(load_bcd[7:0]), .o_Count_Bcd(cnt2), .o_Segments(seg2), .o_Wrap(wrap2)
  );

  bcd_segment_counter #(.NUM_DIGITS(3), .TICK_COUNT(TC), .BLANK_LEADING_ZEROS(1'b1)) dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Run(run), .i_Up(up), .i_Load(load),
    .i_Load_Bcd(load_bcd), .o_Count_Bcd(cnt3), .o_Segments(seg3), .o_Wrap(wrap3)
  );

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct { int c2; int c3; bit w2; bit w3; } exp_t;
  exp_t sb[$];

  int m_c2, m_c3, m_presc;
  bit m_w2, m_w3;
  int errors = 0;
  int checks = 0;

  function automatic logic [23:0] to_bcd(int v, int n);
    logic [23:0] r = '0;
    int p = 1;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [41:0] segs_of(int v, int n, bit blank);
    logic [41:0] r = '0;
    int p = 1;
    for (int k = 0; k < n; k++) begin
      if (blank && k > 0 && (v / p) == 0) r[7*k +: 7] = 7'h7F;
      else                                r[7*k +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_val(logic [11:0] lv, int n);
    int v = 0;
    int p = 1;
    for (int k = 0; k < n; k++) begin
      if (lv[4*k +: 4] <= 4'd9) v = v + int'(lv[4*k +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("count2", 64'(cnt2), 64'(to_bcd(e.c2, 2)));
      chk("wrap2",  64'(wrap2), 64'(e.w2));
      chk("seg2",   64'(seg2), 64'(segs_of(e.c2, 2, 1'b0)));
      chk("count3", 64'(cnt3), 64'(to_bcd(e.c3, 3)));
      chk("wrap3",  64'(wrap3), 64'(e.w3));
      chk("seg3",   64'(seg3), 64'(segs_of(e.c3, 3, 1'b1)));
      $display("edge: cnt2=%h wrap2=%b cnt3=%h wrap3=%b", cnt2, wrap2, cnt3, wrap3);
    end
  end

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic cycle(bit r, bit u, bit l, logic [11:0] lv);
    exp_t e;
    run = r; up = u; load = l; load_bcd = lv;
    @(posedge clk);
    if (!rst_n) begin
      m_c2 = 0; m_c3 = 0; m_presc = 0; m_w2 = 0; m_w3 = 0;
    end else if (l) begin
      m_c2 = load_val(lv, 2); m_c3 = load_val(lv, 3);
      m_presc = 0; m_w2 = 0; m_w3 = 0;
    end else if (r && m_presc == TC - 1) begin
      m_presc = 0;
      if (u) begin
        m_w2 = (m_c2 == 99);  m_c2 = (m_c2 + 1) % 100;
        m_w3 = (m_c3 == 999); m_c3 = (m_c3 + 1) % 1000;
      end else begin
        m_w2 = (m_c2 == 0); m_c2 = (m_c2 + 99) % 100;
        m_w3 = (m_c3 == 0); m_c3 = (m_c3 + 999) % 1000;
      end
    end else begin
      m_w2 = 0; m_w3 = 0;
      if (r) m_presc = m_presc + 1;
    end
    e.c2 = m_c2; e.c3 = m_c3; e.w2 = m_w2; e.w3 = m_w3;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit u_state;
    rst_n = 1'b0; run = 1'b0; up = 1'b1; load = 1'b0; load_bcd = '0;
    m_c2 = 0; m_c3 = 0; m_presc = 0; m_w2 = 0; m_w3 = 0;
    #3;
    chk("reset_count2", 64'(cnt2), 64'(0));
    chk("reset_seg2",   64'(seg2), 64'(segs_of(0, 2, 1'b0)));
    chk("reset_seg3",   64'(seg3), 64'(segs_of(0, 3, 1'b1)));
    chk("reset_wrap",   64'({wrap2, wrap3}), 64'(0));
    cycle(0, 1, 0, 12'h0);
    cycle(0, 1, 0, 12'h0);
    rst_n = 1'b1;

    // Full up-count through 99->00 (3-digit instance crosses 099->100).
    repeat (100 * TC + 8) cycle(1, 1, 0, 12'h0);
    // Down-count, then borrow across digits from 10.
    repeat (3 * TC) cycle(1, 0, 0, 12'h0);
    cycle(1, 0, 1, 12'h010);
    repeat (TC) cycle(1, 0, 0, 12'h0);

    // Load coincident with a tick discards the tick.
    while (m_presc != TC - 1) cycle(1, 1, 0, 12'h0);
    cycle(1, 1, 1, 12'h047);
    repeat (TC + 1) cycle(1, 1, 0, 12'h0);
    cycle(1, 1, 1, 12'h0A3);
    cycle(1, 1, 0, 12'h0);

    // Pause with prescaler at 2, then resume.
    while (m_presc != 2) cycle(1, 1, 0, 12'h0);
    repeat (10) cycle(0, 1, 0, 12'h0);
    repeat (4) cycle(1, 1, 0, 12'h0);

    // Blanking patterns and load while paused.
    cycle(0, 1, 1, 12'h005); cycle(0, 1, 0, 12'h0);
    cycle(0, 1, 1, 12'h100); cycle(0, 1, 0, 12'h0);
    cycle(0, 1, 1, 12'h0F0); cycle(0, 1, 0, 12'h0);
    cycle(0, 0, 1, 12'h000); repeat (TC + 1) cycle(1, 0, 0, 12'h0);

    // Randomized run/direction/load traffic.
    u_state = 1'b1;
    repeat (2500) begin
      bit r, l;
      r = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) u_state = ~u_state;
      l = ($urandom_range(0, 39) == 0);
      cycle(r, u_state, l, 12'($urandom));
    end

    // Asynchronous reset between edges at count 57.
    cycle(1, 1, 1, 12'h057);
    repeat (2) cycle(1, 1, 0, 12'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count2", 64'(cnt2), 64'(0));
    chk("async_seg2",   64'(seg2), 64'(segs_of(0, 2, 1'b0)));
    chk("async_count3", 64'(cnt3), 64'(0));
    chk("async_seg3",   64'(seg3), 64'(segs_of(0, 3, 1'b1)));
    chk("async_wrap",   64'({wrap2, wrap3}), 64'(0));
    cycle(1, 1, 0, 12'h0);
    rst_n = 1'b1;
    repeat (TC + 3) cycle(1, 1, 0, 12'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
